commit_ctrl: RTL and testbench
==============================

COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, number of in-flight entries (power of two).
REQ-002 SHALL have parameter ROB_POS_W, default 4, width of an entry index (log2 ROB_SIZE).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rdy, input, 1, global enable; low freezes all state.
REQ-006 SHALL have port issue, input, 1, allocate-entry request from decoder.
REQ-007 SHALL have port issue_rd, input, 5, destination register of issued instruction.
REQ-008 SHALL have port issue_rob_pos, output, ROB_POS_W, tail index the next issue receives (combinational).
REQ-009 SHALL have port full, output, 1, high when all ROB_SIZE entries busy (combinational).
REQ-010 SHALL have port wb_en, input, 1, result writeback strobe.
REQ-011 SHALL have port wb_rob_pos, input, ROB_POS_W, entry being written back.
REQ-012 SHALL have port wb_val, input, 32, result value.
REQ-013 SHALL have port wb_mispredict, input, 1, entry is a mispredicted branch.
REQ-014 SHALL have port commit, output, 1, registered one-cycle commit pulse to register file.
REQ-015 SHALL have port commit_rd, output, 5, committed destination register.
REQ-016 SHALL have port commit_val, output, 32, committed value.
REQ-017 SHALL have port commit_rob_pos, output, ROB_POS_W, committed entry index.
REQ-018 SHALL have port rollback, output, 1, registered one-cycle flush pulse to register file and pipeline.

Function
REQ-019 SHALL hold per entry: busy, ready, mispredict, rd[4:0], val[31:0]; head, tail pointers (ROB_POS_W, wrap modulo ROB_SIZE) and count (ROB_POS_W+1 bits).
REQ-020 SHALL assert full iff count == ROB_SIZE; issue_rob_pos = tail.
REQ-021 SHALL accept issue when issue && !full && rdy: entry[tail] busy=1, ready=0, mispredict=0, rd=issue_rd; tail+1; issue while full ignored with no state change.
REQ-022 SHALL on wb_en && rdy with entry[wb_rob_pos] busy set ready=1, val=wb_val, mispredict=wb_mispredict; writeback to non-busy entry ignored.
REQ-023 SHALL commit when rdy && entry[head] busy && ready (state at clock edge): next cycle commit=1, commit_rd/val/rob_pos = entry[head]/head; entry busy cleared; head+1; at most one commit per cycle.
REQ-024 SHALL drive commit=0 and rollback=0 on every cycle following an edge with no commit/flush, including edges with rdy low; commit_rd/val/rob_pos otherwise hold last value.
REQ-025 SHALL, when committing entry has mispredict=1, also assert rollback=1 in the same output cycle as commit and flush: all busy cleared, head=tail=0, count=0.
REQ-026 SHALL let flush win over simultaneous issue and writeback: both discarded that edge.
REQ-027 SHALL update count as +1 issue, -1 commit, net 0 when both occur same edge; full evaluated before the edge, so issue refused at count==ROB_SIZE even if a commit occurs that edge.
REQ-028 SHALL allow writeback to the head entry to commit no earlier than the following edge (one-cycle writeback-to-commit latency).
REQ-029 SHALL tolerate issue_rd==0 entries; they commit normally (register file ignores rd 0).

Reset
REQ-030 SHALL on rst high, asynchronously: head=tail=count=0, all busy/ready/mispredict=0, commit=0, rollback=0, commit_rd=0, commit_val=0, commit_rob_pos=0; full=0, issue_rob_pos=0.
REQ-031 SHALL discard any in-flight entries when rst asserts mid-operation and resume with empty buffer on first edge after release.

Verification
REQ-032 SHALL pass: reset, issue rd=5 (pos 0), wb pos0 val=0x1234 -> 2 edges later commit=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=0, count back to 0.
REQ-033 SHALL pass: issue rd=1,2,3; wb pos2 then pos1 then pos0 -> commits in order pos0,1,2 on consecutive cycles after pos0 ready.
REQ-034 SHALL pass: 16 issues -> full=1, 17th issue ignored, tail wraps to 0; wb+commit pos0 and issue same edge -> full stays coherent, new entry at pos0.
REQ-035 SHALL pass: issue 3 entries, wb pos0 mispredict=1 -> commit and rollback both 1 same cycle, next issue_rob_pos=0, count=0, late wb pos1 ignored.
REQ-036 SHALL pass: rdy=0 for 3 cycles with head ready -> no commit, state frozen; rdy=1 -> commit next cycle.
REQ-037 SHALL pass: rst asserted mid-cycle with 4 busy entries -> outputs zero immediately, no commit after release.

Source files
------------

// File: rtl/commit_ctrl.sv
// Reorder-buffer commit controller.
// Tracks in-flight instructions in a circular buffer. It retires them in order
// through a registered commit pulse. A mispredicted branch at the head flushes
// the whole buffer through a registered rollback pulse.
module commit_ctrl #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue,
  input  logic [4:0]           issue_rd,
  output logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 full,
  input  logic                 wb_en,
  input  logic [ROB_POS_W-1:0] wb_rob_pos,
  input  logic [31:0]          wb_val,
  input  logic                 wb_mispredict,
  output logic                 commit,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_val,
  output logic [ROB_POS_W-1:0] commit_rob_pos,
  output logic                 rollback
);

  localparam logic [ROB_POS_W:0]   FULL_COUNT = (ROB_POS_W + 1)'(ROB_SIZE);
  localparam logic [ROB_POS_W:0]   COUNT_ONE  = (ROB_POS_W + 1)'(1);
  localparam logic [ROB_POS_W-1:0] POS_ONE    = (ROB_POS_W)'(1);

  logic [ROB_SIZE-1:0]  busy;
  logic [ROB_SIZE-1:0]  ready;
  logic [ROB_SIZE-1:0]  mispredict;
  logic [4:0]           rd_q  [ROB_SIZE];
  logic [31:0]          val_q [ROB_SIZE];
  logic [ROB_POS_W-1:0] head;
  logic [ROB_POS_W-1:0] tail;
  logic [ROB_POS_W:0]   count;

  logic do_commit;
  logic do_flush;
  logic do_issue;
  logic do_wb;

  assign full          = (count == FULL_COUNT);
  assign issue_rob_pos = tail;

  // A flush discards any issue or writeback arriving on the same edge. Fullness
  // is judged before the edge, so a commit on that edge does not open room for
  // an issue.
  assign do_commit = rdy && busy[head] && ready[head];
  assign do_flush  = do_commit && mispredict[head];
  assign do_issue  = rdy && issue && !full && !do_flush;
  assign do_wb     = rdy && wb_en && busy[wb_rob_pos] && !do_flush;

  // Buffer state, pointers, occupancy and the registered commit/rollback outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      mispredict     <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
      end
      commit         <= 1'b0;
      rollback       <= 1'b0;
      commit_rd      <= '0;
      commit_val     <= '0;
      commit_rob_pos <= '0;
    end else begin
      commit   <= do_commit;
      rollback <= do_flush;
      if (do_commit) begin
        commit_rd      <= rd_q[head];
        commit_val     <= val_q[head];
        commit_rob_pos <= head;
      end
      if (do_flush) begin
        busy       <= '0;
        ready      <= '0;
        mispredict <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
      end else begin
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + POS_ONE;
        end
        if (do_wb) begin
          ready[wb_rob_pos]      <= 1'b1;
          val_q[wb_rob_pos]      <= wb_val;
          mispredict[wb_rob_pos] <= wb_mispredict;
        end
        if (do_issue) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= 1'b0;
          mispredict[tail] <= 1'b0;
          rd_q[tail]       <= issue_rd;
          tail             <= tail + POS_ONE;
        end
        case ({do_issue, do_commit})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed self-checking testbench for commit_ctrl.
module tb_commit_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        full;
  logic        wb_en;
  logic [3:0]  wb_rob_pos;
  logic [31:0] wb_val;
  logic        wb_mispredict;
  logic        commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_pos;
  logic        rollback;

  int passed = 0;
  int total  = 0;

  commit_ctrl #(.ROB_SIZE(16), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos), .full(full),
    .wb_en(wb_en), .wb_rob_pos(wb_rob_pos), .wb_val(wb_val), .wb_mispredict(wb_mispredict),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos), .rollback(rollback)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; issue = 1'b0; issue_rd = '0;
    wb_en = 1'b0; wb_rob_pos = '0; wb_val = '0; wb_mispredict = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    total++;
    if ({commit, rollback, commit_rd, commit_val, commit_rob_pos} !== 43'h0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {commit, rollback, commit_rd, commit_val, commit_rob_pos});
    else passed++;
    total++;
    if ({full, issue_rob_pos} !== 5'h0)
      $display("[TB] FAIL reset_full_pos: got full=%0b pos=%0d expected 0/0", full, issue_rob_pos);
    else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    reset_dut();
    issue = 1'b1; issue_rd = 5'd5;
    total++;
    if (issue_rob_pos !== 4'd0)
      $display("[TB] FAIL single_pos: got %0d expected 0", issue_rob_pos);
    else passed++;
    tick();
    issue = 1'b0;
    wb_en = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'h1234;
    total++;
    if ({commit, issue_rob_pos} !== {1'b0, 4'd1})
      $display("[TB] FAIL single_after_issue: got commit=%0b pos=%0d expected 0/1", commit, issue_rob_pos);
    else passed++;
    tick();
    wb_en = 1'b0;
    total++;
    if (commit !== 1'b0)
      $display("[TB] FAIL single_wb_latency: got commit=%0b expected 0", commit);
    else passed++;
    tick();
    total++;
    if ({commit, rollback, commit_rd, commit_val, commit_rob_pos} !== {1'b1, 1'b0, 5'd5, 32'h1234, 4'd0})
      $display("[TB] FAIL single_commit: got c=%0b rb=%0b rd=%0d val=%h pos=%0d expected 1/0/5/1234/0",
               commit, rollback, commit_rd, commit_val, commit_rob_pos);
    else passed++;
    total++;
    if (dut.count !== 5'd0)
      $display("[TB] FAIL single_count: got %0d expected 0", dut.count);
    else passed++;
    tick();
    total++;
    if ({commit, commit_rd, commit_val} !== {1'b0, 5'd5, 32'h1234})
      $display("[TB] FAIL single_hold: got c=%0b rd=%0d val=%h expected 0/5/1234", commit, commit_rd, commit_val);
    else passed++;
  endtask

  task automatic test_in_order();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      issue = 1'b1; issue_rd = 5'(i + 1);
      tick();
    end
    issue = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      wb_en = 1'b1; wb_rob_pos = 4'(k); wb_val = 32'hA0 + 32'(k);
      tick();
      total++;
      if (commit !== 1'b0)
        $display("[TB] FAIL order_no_early_commit: wb pos%0d got commit=%0b expected 0", k, commit);
      else passed++;
    end
    wb_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({commit, commit_rd, commit_val, commit_rob_pos} !== {1'b1, 5'(k + 1), 32'hA0 + 32'(k), 4'(k)})
        $display("[TB] FAIL order_commit%0d: got c=%0b rd=%0d val=%h pos=%0d expected 1/%0d/%h/%0d",
                 k, commit, commit_rd, commit_val, commit_rob_pos, k + 1, 32'hA0 + 32'(k), k);
      else passed++;
    end
    tick();
    total++;
    if (commit !== 1'b0)
      $display("[TB] FAIL order_drained: got commit=%0b expected 0", commit);
    else passed++;
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      issue = 1'b1; issue_rd = 5'(i + 1);
      tick();
    end
    issue_rd = 5'd31;
    total++;
    if ({full, issue_rob_pos} !== {1'b1, 4'd0})
      $display("[TB] FAIL full_set: got full=%0b pos=%0d expected 1/0", full, issue_rob_pos);
    else passed++;
    tick();
    total++;
    if ({full, issue_rob_pos, dut.count} !== {1'b1, 4'd0, 5'd16})
      $display("[TB] FAIL full_ignore: got full=%0b pos=%0d count=%0d expected 1/0/16",
               full, issue_rob_pos, dut.count);
    else passed++;
    wb_en = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'hF00;
    tick();
    wb_en = 1'b0;
    total++;
    if ({commit, full} !== 2'b01)
      $display("[TB] FAIL full_wb: got commit=%0b full=%0b expected 0/1", commit, full);
    else passed++;
    tick();
    total++;
    if ({commit, commit_rd, commit_val, commit_rob_pos, full, issue_rob_pos} !==
        {1'b1, 5'd1, 32'hF00, 4'd0, 1'b0, 4'd0})
      $display("[TB] FAIL full_commit: got c=%0b rd=%0d val=%h pos=%0d full=%0b tail=%0d expected 1/1/f00/0/0/0",
               commit, commit_rd, commit_val, commit_rob_pos, full, issue_rob_pos);
    else passed++;
    tick();
    issue = 1'b0;
    total++;
    if ({commit, full, issue_rob_pos, dut.count} !== {1'b0, 1'b1, 4'd1, 5'd16})
      $display("[TB] FAIL full_reissue: got c=%0b full=%0b tail=%0d count=%0d expected 0/1/1/16",
               commit, full, issue_rob_pos, dut.count);
    else passed++;
  endtask

  task automatic test_mispredict();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      issue = 1'b1; issue_rd = 5'(i + 7);
      tick();
    end
    issue = 1'b0;
    wb_en = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'h55; wb_mispredict = 1'b1;
    tick();
    total++;
    if ({commit, rollback} !== 2'b00)
      $display("[TB] FAIL mis_early: got c=%0b rb=%0b expected 0/0", commit, rollback);
    else passed++;
    issue = 1'b1; issue_rd = 5'd4;
    wb_en = 1'b1; wb_rob_pos = 4'd1; wb_val = 32'h66; wb_mispredict = 1'b0;
    tick();
    issue = 1'b0;
    wb_en = 1'b1; wb_rob_pos = 4'd1; wb_val = 32'h99;
    total++;
    if ({commit, rollback, commit_rd, commit_val, commit_rob_pos} !== {1'b1, 1'b1, 5'd7, 32'h55, 4'd0})
      $display("[TB] FAIL mis_flush: got c=%0b rb=%0b rd=%0d val=%h pos=%0d expected 1/1/7/55/0",
               commit, rollback, commit_rd, commit_val, commit_rob_pos);
    else passed++;
    total++;
    if ({issue_rob_pos, full, dut.count} !== {4'd0, 1'b0, 5'd0})
      $display("[TB] FAIL mis_empty: got tail=%0d full=%0b count=%0d expected 0/0/0",
               issue_rob_pos, full, dut.count);
    else passed++;
    tick();
    wb_en = 1'b0;
    total++;
    if ({commit, rollback} !== 2'b00)
      $display("[TB] FAIL mis_pulse: got c=%0b rb=%0b expected 0/0", commit, rollback);
    else passed++;
    tick();
    total++;
    if ({commit, rollback, issue_rob_pos} !== {1'b0, 1'b0, 4'd0})
      $display("[TB] FAIL mis_late_wb: got c=%0b rb=%0b tail=%0d expected 0/0/0", commit, rollback, issue_rob_pos);
    else passed++;
  endtask

  task automatic test_rdy_stall();
    reset_dut();
    issue = 1'b1; issue_rd = 5'd10;
    tick();
    issue = 1'b0;
    wb_en = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'h77;
    tick();
    wb_en = 1'b0;
    rdy = 1'b0; issue = 1'b1; issue_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({commit, issue_rob_pos} !== {1'b0, 4'd1})
        $display("[TB] FAIL stall_cycle%0d: got c=%0b tail=%0d expected 0/1", i, commit, issue_rob_pos);
      else passed++;
    end
    rdy = 1'b1; issue = 1'b0;
    tick();
    total++;
    if ({commit, commit_rd, commit_val, commit_rob_pos} !== {1'b1, 5'd10, 32'h77, 4'd0})
      $display("[TB] FAIL stall_release: got c=%0b rd=%0d val=%h pos=%0d expected 1/10/77/0",
               commit, commit_rd, commit_val, commit_rob_pos);
    else passed++;
  endtask

  task automatic test_mid_reset();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1; issue_rd = 5'(i + 1);
      tick();
    end
    issue = 1'b0;
    wb_en = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'hB0;
    tick();
    issue = 1'b1; issue_rd = 5'd5;
    wb_en = 1'b1; wb_rob_pos = 4'd1; wb_val = 32'hB1;
    tick();
    issue = 1'b0; wb_en = 1'b0;
    total++;
    if ({commit, commit_rd, issue_rob_pos, dut.count} !== {1'b1, 5'd1, 4'd5, 5'd4})
      $display("[TB] FAIL midrst_pre: got c=%0b rd=%0d tail=%0d count=%0d expected 1/1/5/4",
               commit, commit_rd, issue_rob_pos, dut.count);
    else passed++;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({commit, rollback, commit_rd, commit_val, commit_rob_pos, full, issue_rob_pos} !== 48'h0)
      $display("[TB] FAIL midrst_async: got c=%0b rb=%0b rd=%0d val=%h pos=%0d full=%0b tail=%0d expected all 0",
               commit, rollback, commit_rd, commit_val, commit_rob_pos, full, issue_rob_pos);
    else passed++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({commit, issue_rob_pos, dut.count} !== {1'b0, 4'd0, 5'd0})
        $display("[TB] FAIL midrst_after%0d: got c=%0b tail=%0d count=%0d expected 0/0/0",
                 i, commit, issue_rob_pos, dut.count);
      else passed++;
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_in_order();
    test_full();
    test_mispredict();
    test_rdy_stall();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
